// File: rtl/move_stream_serializer_if.sv
// Handshake/bus bundle for move_stream_serializer: word load side and per-move output side.
interface move_stream_serializer_if #(
  parameter int FIELD_W = 4,
  parameter int MOVES   = 2,
  parameter int CNT_W   = 4
) ();
  logic                       load;
  logic [MOVES*4*FIELD_W-1:0] in;
  logic                       skip_null;
  logic                       out_ready;
  logic                       out_valid;
  logic [FIELD_W-1:0]         out1;
  logic [FIELD_W-1:0]         out2;
  logic [FIELD_W-1:0]         out3;
  logic [FIELD_W-1:0]         out4;
  logic                       busy;
  logic [CNT_W-1:0]           move_counter_out;
  logic                       done;

  modport master (
    output load, in, skip_null, out_ready,
    input  out_valid, out1, out2, out3, out4, busy, move_counter_out, done
  );

  modport slave (
    input  load, in, skip_null, out_ready,
    output out_valid, out1, out2, out3, out4, busy, move_counter_out, done
  );
endinterface

// File: rtl/move_stream_serializer.sv
// Serializes a packed word of MOVES chess moves into one move per valid/ready transfer,
// optionally dropping all-zero (null) moves, with a per-word transfer counter and done flag.
module move_stream_serializer #(
  parameter int FIELD_W = 4,
  parameter int MOVES   = 2,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic rst_n,
  move_stream_serializer_if.slave bus
);
  localparam int MOVE_W = 4 * FIELD_W;
  localparam int WORD_W = MOVES * MOVE_W;
  localparam int IDX_W  = (MOVES > 1) ? $clog2(MOVES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [WORD_W-1:0] word;
  logic              skip;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              valid_r;
  logic              done_r;
  logic [MOVE_W-1:0] move_r;

  logic [MOVE_W-1:0] move_arr [MOVES];
  logic [MOVE_W-1:0] load_move0;
  logic [MOVE_W-1:0] nxt_move;
  logic [IDX_W-1:0]  nidx;
  logic              is_last;
  logic              advance;
  logic              transfer;

  // Move 0 sits in the most-significant slice of the word.
  for (genvar g = 0; g < MOVES; g++) begin : g_slice
    assign move_arr[g] = word[(MOVES-1-g)*MOVE_W +: MOVE_W];
  end

  assign load_move0 = bus.in[WORD_W-1 -: MOVE_W];

  always_comb begin
    is_last  = (idx == IDX_W'(MOVES - 1));
    nidx     = is_last ? '0 : idx + 1'b1;
    nxt_move = move_arr[nidx];
    transfer = valid_r && bus.out_ready;
    // A skip bubble (valid low while emitting) always advances unconditionally.
    advance  = (state == S_EMIT) && (!valid_r || bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      word    <= '0;
      skip    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      move_r  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.load) begin
            word   <= bus.in;
            skip   <= bus.skip_null;
            idx    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
            state  <= S_EMIT;
            if (bus.skip_null && (load_move0 == '0)) begin
              valid_r <= 1'b0;
            end else begin
              valid_r <= 1'b1;
              move_r  <= load_move0;
            end
          end
        end
        S_EMIT: begin
          if (advance) begin
            if (transfer) cnt <= cnt + 1'b1;
            if (is_last) begin
              state   <= S_DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              idx <= nidx;
              if (skip && (nxt_move == '0)) begin
                valid_r <= 1'b0;
              end else begin
                valid_r <= 1'b1;
                move_r  <= nxt_move;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid        = valid_r;
  assign bus.out1             = move_r[4*FIELD_W-1 -: FIELD_W];
  assign bus.out2             = move_r[3*FIELD_W-1 -: FIELD_W];
  assign bus.out3             = move_r[2*FIELD_W-1 -: FIELD_W];
  assign bus.out4             = move_r[FIELD_W-1:0];
  assign bus.busy             = (state == S_EMIT);
  assign bus.move_counter_out = cnt;
  assign bus.done             = done_r;
endmodule

// File: tb/tb_move_stream_serializer.sv
// Directed bench for move_stream_serializer: default instance plus a FIELD_W=3, MOVES=4 instance.
module tb_move_stream_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  move_stream_serializer_if #(.FIELD_W(4), .MOVES(2), .CNT_W(4)) d_if ();
  move_stream_serializer_if #(.FIELD_W(3), .MOVES(4), .CNT_W(4)) p_if ();

  move_stream_serializer #(.FIELD_W(4), .MOVES(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(d_if.slave)
  );
  move_stream_serializer #(.FIELD_W(3), .MOVES(4), .CNT_W(4)) u_pdut (
    .clk(clk), .rst_n(rst_n), .bus(p_if.slave)
  );

  // status = {out_valid, busy, done, move_counter_out}
  function automatic logic [6:0] dstat();
    return {d_if.out_valid, d_if.busy, d_if.done, d_if.move_counter_out};
  endfunction
  function automatic logic [15:0] dflds();
    return {d_if.out1, d_if.out2, d_if.out3, d_if.out4};
  endfunction
  function automatic logic [6:0] pstat();
    return {p_if.out_valid, p_if.busy, p_if.done, p_if.move_counter_out};
  endfunction
  function automatic logic [11:0] pflds();
    return {p_if.out1, p_if.out2, p_if.out3, p_if.out4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dload(input logic [31:0] word, input logic skip);
    d_if.in = word;
    d_if.skip_null = skip;
    d_if.load = 1'b1;
    tick();
    d_if.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (dstat() !== 7'b000_0000) begin
      failures++; $display("FAIL reset_status got=%b exp=%b", dstat(), 7'b000_0000);
    end
    checks++;
    if (dflds() !== 16'h0000) begin
      failures++; $display("FAIL reset_fields got=%h exp=%h", dflds(), 16'h0000);
    end
    checks++;
    if (pstat() !== 7'b000_0000 || pflds() !== 12'o0000) begin
      failures++; $display("FAIL reset_param got=%b/%o exp=0/0", pstat(), pflds());
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_walk();
    d_if.out_ready = 1'b1;
    dload(32'h12345670, 1'b0);
    checks++;
    if (dflds() !== 16'h1234 || dstat() !== {3'b110, 4'd0}) begin
      failures++; $display("FAIL walk_m0 got=%h/%b exp=1234/%b", dflds(), dstat(), {3'b110, 4'd0});
    end
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b110, 4'd1}) begin
      failures++; $display("FAIL walk_m1 got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b110, 4'd1});
    end
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b001, 4'd2}) begin
      failures++; $display("FAIL walk_done got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b001, 4'd2});
    end
  endtask

  task automatic test_backpressure();
    d_if.out_ready = 1'b0;
    dload(32'h12345670, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dflds() !== 16'h1234 || dstat() !== {3'b110, 4'd0}) begin
        failures++; $display("FAIL bp_hold%0d got=%h/%b exp=1234/%b", i, dflds(), dstat(), {3'b110, 4'd0});
      end
      if (i < 2) tick();
    end
    d_if.out_ready = 1'b1;
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b110, 4'd1}) begin
      failures++; $display("FAIL bp_m1 got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b110, 4'd1});
    end
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd2}) begin
      failures++; $display("FAIL bp_done got=%b exp=%b", dstat(), {3'b001, 4'd2});
    end
  endtask

  task automatic test_null_skip();
    d_if.out_ready = 1'b1;
    dload(32'h00005670, 1'b1);
    checks++;
    if (dstat() !== {3'b010, 4'd0}) begin
      failures++; $display("FAIL skip_bubble got=%b exp=%b", dstat(), {3'b010, 4'd0});
    end
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b110, 4'd0}) begin
      failures++; $display("FAIL skip_m1 got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b110, 4'd0});
    end
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd1}) begin
      failures++; $display("FAIL skip_done got=%b exp=%b", dstat(), {3'b001, 4'd1});
    end
    dload(32'h00005670, 1'b0);
    checks++;
    if (dflds() !== 16'h0000 || dstat() !== {3'b110, 4'd0}) begin
      failures++; $display("FAIL noskip_m0 got=%h/%b exp=0000/%b", dflds(), dstat(), {3'b110, 4'd0});
    end
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b110, 4'd1}) begin
      failures++; $display("FAIL noskip_m1 got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b110, 4'd1});
    end
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd2}) begin
      failures++; $display("FAIL noskip_done got=%b exp=%b", dstat(), {3'b001, 4'd2});
    end
    // all-null word with skip: two bubbles, then done with nothing counted
    dload(32'h00000000, 1'b1);
    checks++;
    if (dstat() !== {3'b010, 4'd0}) begin
      failures++; $display("FAIL allnull_b0 got=%b exp=%b", dstat(), {3'b010, 4'd0});
    end
    tick();
    checks++;
    if (dstat() !== {3'b010, 4'd0}) begin
      failures++; $display("FAIL allnull_b1 got=%b exp=%b", dstat(), {3'b010, 4'd0});
    end
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd0}) begin
      failures++; $display("FAIL allnull_done got=%b exp=%b", dstat(), {3'b001, 4'd0});
    end
  endtask

  task automatic test_load_during_emit();
    d_if.out_ready = 1'b0;
    dload(32'h12345670, 1'b0);
    tick();
    dload(32'hFFFFFFFF, 1'b1);
    checks++;
    if (dflds() !== 16'h1234 || dstat() !== {3'b110, 4'd0}) begin
      failures++; $display("FAIL emitload_hold got=%h/%b exp=1234/%b", dflds(), dstat(), {3'b110, 4'd0});
    end
    d_if.out_ready = 1'b1;
    tick();
    checks++;
    if (dflds() !== 16'h5670 || dstat() !== {3'b110, 4'd1}) begin
      failures++; $display("FAIL emitload_m1 got=%h/%b exp=5670/%b", dflds(), dstat(), {3'b110, 4'd1});
    end
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd2}) begin
      failures++; $display("FAIL emitload_done got=%b exp=%b", dstat(), {3'b001, 4'd2});
    end
  endtask

  task automatic test_reset_mid();
    d_if.out_ready = 1'b1;
    dload(32'h12345670, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (dstat() !== 7'b000_0000 || dflds() !== 16'h0000) begin
      failures++; $display("FAIL midrst_clear got=%b/%h exp=0/0", dstat(), dflds());
    end
    tick();
    checks++;
    if (dstat() !== 7'b000_0000) begin
      failures++; $display("FAIL midrst_idle got=%b exp=%b", dstat(), 7'b000_0000);
    end
    dload(32'h12345670, 1'b0);
    checks++;
    if (dflds() !== 16'h1234 || dstat() !== {3'b110, 4'd0}) begin
      failures++; $display("FAIL midrst_m0 got=%h/%b exp=1234/%b", dflds(), dstat(), {3'b110, 4'd0});
    end
    tick();
    tick();
    checks++;
    if (dstat() !== {3'b001, 4'd2}) begin
      failures++; $display("FAIL midrst_done got=%b exp=%b", dstat(), {3'b001, 4'd2});
    end
  endtask

  task automatic test_param_reload();
    logic [11:0] pexp [4];
    pexp[0] = 12'o1234;
    pexp[1] = 12'o5671;
    pexp[2] = 12'o2345;
    pexp[3] = 12'o7654;
    p_if.out_ready = 1'b1;
    p_if.skip_null = 1'b0;
    p_if.in = '0;
    p_if.load = 1'b1;
    tick();
    p_if.load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pstat() !== {3'b001, 4'd4}) begin
      failures++; $display("FAIL param_first_done got=%b exp=%b", pstat(), {3'b001, 4'd4});
    end
    p_if.in = {pexp[0], pexp[1], pexp[2], pexp[3]};
    p_if.load = 1'b1;
    tick();
    p_if.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pflds() !== pexp[i] || pstat() !== {3'b110, 4'(i)}) begin
        failures++; $display("FAIL param_m%0d got=%o/%b exp=%o/%b", i, pflds(), pstat(), pexp[i], {3'b110, 4'(i)});
      end
      tick();
    end
    checks++;
    if (pstat() !== {3'b001, 4'd4} || pflds() !== pexp[3]) begin
      failures++; $display("FAIL param_done got=%b/%o exp=%b/%o", pstat(), pflds(), {3'b001, 4'd4}, pexp[3]);
    end
  endtask

  initial begin
    d_if.load = 1'b0;
    d_if.in = '0;
    d_if.skip_null = 1'b0;
    d_if.out_ready = 1'b0;
    p_if.load = 1'b0;
    p_if.in = '0;
    p_if.skip_null = 1'b0;
    p_if.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic_walk();
    test_backpressure();
    test_null_skip();
    test_load_during_emit();
    test_reset_mid();
    test_param_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/move_stream_serializer.md
# move_stream_serializer

Parametrised successor to the fixed 32-bit move serializer. Accepts a packed word of `MOVES` chess moves and emits them one move per handshake on four coordinate fields (from-file, from-rank, to-file, to-rank). Adds a valid/ready output handshake, an optional null-move skip mode, a per-word move counter and a sticky completion flag. Sits between the move generator and the move-evaluation/board-update logic.

## Interface
- `FIELD_W`, 4: width of one coordinate field.
- `MOVES`, 2: moves per loaded word. Legal range is 1 to 2**`CNT_W`-1.
- `CNT_W`, 4: width of the move counter.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `load`  in  1  capture `in` and `skip_null`; honoured only in IDLE or DONE.
- `in`  in  `MOVES*4*FIELD_W`  packed moves:
  - Move 0 occupies the most-significant `4*FIELD_W` bits.
  - Within a move, fields from MSB to LSB are from-file, from-rank, to-file, to-rank.
- `skip_null`  in  1  mode bit, latched on an accepted `load`. When 1, moves whose four fields are all zero are dropped.
- `out_ready`  in  1  downstream accepts the presented move.
- `out_valid`  out  1  `out1`..`out4` hold a move to transfer.
- `out1`, `out2`, `out3`, `out4`  out  `FIELD_W` each  from-file, from-rank, to-file, to-rank of the current move.
- `busy`  out  1  high in the EMIT state.
- `move_counter_out`  out  `CNT_W`  number of moves transferred since the last accepted load.
- `done`  out  1  level; high in the DONE state.

## Operation
- States:
  - IDLE: entered on reset.
  - EMIT: walking the captured word.
  - DONE: word exhausted.
- IDLE or DONE, with `load`=1:
  - Capture `in` into the holding register and latch `skip_null`.
  - Index <= 0; `move_counter_out` <= 0; `done` <= 0.
  - Next state is EMIT.
- In EMIT, at each edge the move at the current index is evaluated:
  - **Null and skipping:** if the move is null and latched skip is 1, `out_valid` is 0 for one cycle, the index advances and the counter is unchanged.
  - **Otherwise, presenting:** `out1`..`out4` are driven with the move's fields and `out_valid`=1.
  - **Holding:** while `out_ready`=0, fields and `out_valid` hold stable.
  - **Transfer:** `out_valid` && `out_ready` at an edge is a transfer. The counter increments by 1 and the index advances.
- Index advance past `MOVES-1`, by either transfer or skip:
  - Next state is DONE.
  - `out_valid` <= 0; `done` <= 1.
  - `out1`..`out4` hold the last presented values.
- `load` while in EMIT is ignored. The captured word, index and counter are unaffected.
- A word that is entirely null with skip enabled reaches DONE after `MOVES` cycles with the counter at 0. Nothing is emitted.
- The counter never wraps, because `MOVES` is less than 2**`CNT_W` by parameter rule.
- Index width is clog2(`MOVES`), minimum 1. Fields are extracted by index, with no arithmetic on field values.

## Timing
- Reset: `rst_n`=0 at a rising edge forces the following regardless of state, including mid-EMIT:
  - IDLE state.
  - `out_valid`, `busy`, `done`, `move_counter_out` and `out1`..`out4` all 0.
  - The captured word is discarded.
- Latency: `load` sampled at edge k causes move 0 to appear registered after edge k, with `out_valid`=1 and `busy`=1 (non-skipped case).
- With `out_ready` held at 1 and no skips, move i is presented in cycle k+i. `done`=1 after edge k+`MOVES`.
- Each skipped move costs exactly one bubble cycle.
- `out_ready` may change freely. Data must not change while `out_valid`=1 and `out_ready`=0.
- A `load` in DONE at edge j takes effect at edge j: `done`=0 and `out_valid` for the new move 0 appear in the same cycle.

## Test plan
- **Basic walk.** Defaults; `in`=0x12345670, `skip_null`=0, `load` pulsed for one cycle, `out_ready`=1.
  - Cycle 1: out1..4 = 1,2,3,4 with valid.
  - Cycle 2: out1..4 = 5,6,7,0 with valid.
  - Then `done`=1, `move_counter_out`=2, `busy`=0.
- **Backpressure.** Same load with `out_ready`=0 for 3 cycles, then 1.
  - out1..4 hold 1,2,3,4 and the counter holds 0 for 3 cycles.
  - Completion is 2 cycles after `out_ready` rises; counter ends at 2.
- **Null skip.** `in`=0x00005670.
  - With `skip_null`=1: one bubble, then 5,6,7,0 is transferred; final counter is 1.
  - With `skip_null`=0: 0,0,0,0 is transferred first; final counter is 2.
- **Load during EMIT.** Load 0x12345670 with `out_ready`=0, then pulse `load` with `in`=0xFFFFFFFF.
  - Ignored: the outputs still present 1,2,3,4.
  - Stream finishes as in the basic walk.
- **Reset mid-stream.** `rst_n`=0 for one edge after move 0 transfers.
  - All outputs 0 and IDLE state.
  - A subsequent load restarts cleanly with the counter from 0.
- **Parametrised reload.** `FIELD_W`=3, `MOVES`=4.
  - Load 4 distinct moves from DONE: `done` drops and 4 transfers follow in MSB-first order.
  - Final counter is 4.
